score_video_gen: RTL and testbench

SCORE_VIDEO_GEN -- requirements
Module: score_video_gen

---
 rtl/score_video_gen.sv | 188 ++++++++++++++++++
 tb/tb_score_video_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_video_gen.sv
// score_video_gen: renders a NUM_DIGITS-digit BCD score as 7-segment glyphs into a 1-bit
// pixel stream. The digit cells are 16x32 px, spaced PITCH px apart, with their top-left corner
// at (X0, Y0). The pipeline has two register stages, so score lags hcount/vcount by 2 clocks.
//
// Ports
//   clk7_159    : pixel clock, the only clock
//   reset       : synchronous, active-high reset
//   hcount      : current pixel column (9 bits)
//   vcount      : current line (9 bits)
//   frame_start : one-cycle pulse at the start of vertical blank; latches the shadow inputs
//   digits      : packed BCD, digit 0 (most significant) in the top nibble
//   lz_blank    : blank leading zeros (the last digit is always shown)
//   blink_en    : blink the whole score, BLINK_FRAMES frames on, then BLINK_FRAMES frames off
//   score       : registered score pixel
module score_video_gen #(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned X0           = 160,
    parameter int unsigned Y0           = 32,
    parameter int unsigned PITCH        = 32,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                    clk7_159,
    input  logic                    reset,
    input  logic [8:0]              hcount,
    input  logic [8:0]              vcount,
    input  logic                    frame_start,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic                    score
);

    localparam int unsigned DW = 4 * NUM_DIGITS;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // Shadow copies, loaded only on frame_start.
    logic [DW-1:0] dig_q;
    logic          lz_q;
    logic          ben_q;
    logic [7:0]    cnt_q, cnt_d;
    logic          phase_q, phase_d;

    // Display copies lag the shadows by one cycle. A pixel that arrives together with
    // frame_start is evaluated in stage 2 one cycle later; the lag makes it still see the
    // previous shadow values, while the next pixel sees the new ones.
    logic [DW-1:0] disp_dig_q;
    logic          disp_lz_q;
    logic          disp_vis_q;

    // Stage 1 pipeline registers.
    logic          in_cell_q, in_cell_d;
    logic [IW-1:0] cell_q, cell_d;
    logic [3:0]    lx_q, lx_d;
    logic [4:0]    ly_q, ly_d;

    logic          score_d;

    // Blink counter: cleared while blinking is disabled, and advanced once per frame otherwise.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!ben_q) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (frame_start) begin
            if (cnt_q >= BLINK_LAST) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Stage 1: decode the cell index and the cell-local coordinates. Coordinates are
    // 10-bit, and cells whose left edge lies beyond column 511 are excluded.
    logic [9:0] h10, v10, dx, dy;
    logic       in_y;

    always_comb begin
        h10       = {1'b0, hcount};
        v10       = {1'b0, vcount};
        dy        = v10 - 10'(Y0);
        in_y      = (Y0 <= 32'd511) && (v10 >= 10'(Y0)) && (dy < 10'd32);
        dx        = '0;
        in_cell_d = 1'b0;
        cell_d    = '0;
        lx_d      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (X0 + k * PITCH <= 32'd511) begin
                dx = h10 - 10'(X0 + k * PITCH);
                if ((h10 >= 10'(X0 + k * PITCH)) && (dx < 10'd16)) begin
                    in_cell_d = in_y;
                    cell_d    = IW'(k);
                    lx_d      = dx[3:0];
                end
            end
        end
        ly_d = dy[4:0];
    end

    // Segment set for one BCD digit as {a,b,c,d,e,f,g}. Codes 10-15 light nothing.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        unique case (n)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Stage 2: select the digit, apply leading-zero blanking, and test segment regions.
    logic [3:0] nib, dk;
    logic       lead, blanked, hit;
    logic [6:0] seg;
    logic       xl, xr, yt, yb;

    always_comb begin
        nib     = 4'd0;
        blanked = 1'b0;
        lead    = disp_lz_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dk   = disp_dig_q[4*(NUM_DIGITS-1-k) +: 4];
            // lead stays set while every digit from 0 up to k is zero
            lead = lead & (dk == 4'd0);
            if (cell_q == IW'(k)) begin
                nib     = dk;
                blanked = lead && (k != int'(NUM_DIGITS) - 1);
            end
        end
        seg = seg7(nib);
        xl  = (lx_q <= 4'd3);
        xr  = (lx_q >= 4'd12);
        yt  = (ly_q <= 5'd15);
        yb  = (ly_q >= 5'd16);
        hit = (seg[6] && (ly_q <= 5'd3))
            | (seg[5] && xr && yt)
            | (seg[4] && xr && yb)
            | (seg[3] && (ly_q >= 5'd28))
            | (seg[2] && xl && yb)
            | (seg[1] && xl && yt)
            | (seg[0] && (ly_q >= 5'd14) && (ly_q <= 5'd17));
        score_d = in_cell_q & hit & ~blanked & disp_vis_q;
    end

    always_ff @(posedge clk7_159) begin
        if (reset) begin
            dig_q      <= '0;
            lz_q       <= 1'b0;
            ben_q      <= 1'b0;
            cnt_q      <= 8'd0;
            phase_q    <= 1'b0;
            disp_dig_q <= '0;
            disp_lz_q  <= 1'b0;
            disp_vis_q <= 1'b0;
            in_cell_q  <= 1'b0;
            cell_q     <= '0;
            lx_q       <= '0;
            ly_q       <= '0;
            score      <= 1'b0;
        end else begin
            if (frame_start) begin
                dig_q <= digits;
                lz_q  <= lz_blank;
                ben_q <= blink_en;
            end
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            disp_dig_q <= dig_q;
            disp_lz_q  <= lz_q;
            disp_vis_q <= ~phase_q;
            in_cell_q  <= in_cell_d;
            cell_q     <= cell_d;
            lx_q       <= lx_d;
            ly_q       <= ly_d;
            score      <= score_d;
        end
    end

endmodule

// File: tb/tb_score_video_gen.sv
// Testbench for score_video_gen. A behavioural pixel model computes the expected score from
// the cell geometry, the segment regions and the latched frame state. A compare process checks
// the DUT against this model on every cycle. Hand-computed pixel checks fix the model's results
// at known points.
module tb_score_video_gen;

    localparam int ND = 2;
    localparam int X0 = 160;
    localparam int Y0 = 32;
    localparam int PITCH = 32;
    localparam int BF = 2;

    logic            clk7_159 = 1'b0;
    logic            reset = 1'b1;
    logic [8:0]      hcount = '0;
    logic [8:0]      vcount = '0;
    logic            frame_start = 1'b0;
    logic [4*ND-1:0] digits = '0;
    logic            lz_blank = 1'b0;
    logic            blink_en = 1'b0;
    logic            score;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    score_video_gen #(
        .NUM_DIGITS  (ND),
        .X0          (X0),
        .Y0          (Y0),
        .PITCH       (PITCH),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk7_159   (clk7_159),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .frame_start(frame_start),
        .digits     (digits),
        .lz_blank   (lz_blank),
        .blink_en   (blink_en),
        .score      (score)
    );

    initial forever #5 clk7_159 = ~clk7_159;

    function automatic string segs_of(int n);
        case (n)
            0: return "abcdef";
            1: return "bc";
            2: return "abdeg";
            3: return "abcdg";
            4: return "bcfg";
            5: return "acdfg";
            6: return "acdefg";
            7: return "abc";
            8: return "abcdefg";
            9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit has_seg(string s, byte c);
        for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Expected pixel, derived directly from the geometry and the segment regions.
    function automatic bit model_pix(int h, int v, logic [4*ND-1:0] dg, bit lz, bit vis);
        int x, y, left, n;
        bit all_zero;
        string s;
        if (!vis) return 1'b0;
        if (v < Y0 || v > Y0 + 31) return 1'b0;
        y = v - Y0;
        all_zero = 1'b1;
        for (int k = 0; k < ND; k++) begin
            n = int'((dg >> (4 * (ND - 1 - k))) & 'hF);
            all_zero = all_zero && (n == 0);
            left = X0 + k * PITCH;
            if (left <= 511 && h >= left && h <= left + 15) begin
                if (lz && all_zero && k != ND - 1) return 1'b0;
                x = h - left;
                s = segs_of(n);
                return (has_seg(s, "a") && y <= 3)
                    || (has_seg(s, "b") && x >= 12 && y <= 15)
                    || (has_seg(s, "c") && x >= 12 && y >= 16)
                    || (has_seg(s, "d") && y >= 28)
                    || (has_seg(s, "e") && x <= 3 && y >= 16)
                    || (has_seg(s, "f") && x <= 3 && y <= 15)
                    || (has_seg(s, "g") && y >= 14 && y <= 17);
            end
        end
        return 1'b0;
    endfunction

    // Model frame state. A pixel is evaluated with the state as it stood before this edge's
    // frame_start update, and its result appears one edge later.
    logic [4*ND-1:0] m_dig;
    bit m_lz, m_ben, m_phase, p1, exp_score;
    int m_cnt;

    always @(posedge clk7_159) begin
        if (reset) begin
            exp_score <= 1'b0;
            p1        <= 1'b0;
            m_dig     <= '0;
            m_lz      <= 1'b0;
            m_ben     <= 1'b0;
            m_cnt     <= 0;
            m_phase   <= 1'b0;
        end else begin
            exp_score <= p1;
            p1        <= model_pix(int'(hcount), int'(vcount), m_dig, m_lz, !m_phase);
            if (frame_start) begin
                m_dig <= digits;
                m_lz  <= lz_blank;
                m_ben <= blink_en;
            end
            if (!m_ben) begin
                m_cnt   <= 0;
                m_phase <= 1'b0;
            end else if (frame_start) begin
                if (m_cnt == BF - 1) begin
                    m_cnt   <= 0;
                    m_phase <= !m_phase;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk7_159) begin
        if (chk_en) begin
            checks++;
            if (score !== exp_score) begin
                errors++;
                $display("FAIL model h=%0d v=%0d score=%b expected=%b t=%0t",
                         hcount, vcount, score, exp_score, $time);
            end
        end
    end

    task automatic check_lit(string name, logic exp);
        checks++;
        if (score !== exp) begin
            errors++;
            $display("FAIL %s score=%b expected=%b", name, score, exp);
        end
    endtask

    task automatic pin(int h, int v, logic exp, string name);
        @(negedge clk7_159);
        hcount = 9'(h);
        vcount = 9'(v);
        @(negedge clk7_159);
        @(negedge clk7_159);
        check_lit(name, exp);
    endtask

    task automatic fs(logic [4*ND-1:0] dg, logic lz, logic ben);
        @(negedge clk7_159);
        hcount      = '0;
        vcount      = '0;
        digits      = dg;
        lz_blank    = lz;
        blink_en    = ben;
        frame_start = 1'b1;
        @(negedge clk7_159);
        frame_start = 1'b0;
    endtask

    task automatic scan();
        for (int v = Y0 - 2; v <= Y0 + 33; v++) begin
            for (int h = X0 - 1; h <= X0 + PITCH + 16; h++) begin
                @(negedge clk7_159);
                hcount = 9'(h);
                vcount = 9'(v);
            end
        end
    endtask

    initial begin
        bit blink_exp [9] = '{1, 1, 0, 0, 1, 1, 0, 1, 1};

        reset = 1'b1;
        repeat (2) @(negedge clk7_159);
        check_lit("reset_state", 1'b0);
        reset  = 1'b0;
        chk_en = 1'b1;

        // 38: digit 0 renders as 3
        fs(8'h38, 1'b0, 1'b0);
        pin(160, 40, 1'b0, "d38_160_40");
        pin(175, 40, 1'b1, "d38_175_40");
        pin(167, 48, 1'b1, "d38_g");
        pin(162, 52, 1'b0, "d38_no_e");
        pin(180, 40, 1'b0, "gap_180_40");
        scan();

        // Leading-zero blanking
        fs(8'h05, 1'b1, 1'b0);
        pin(161, 33, 1'b0, "lz05_cell0");
        pin(193, 33, 1'b1, "lz05_cell1_a");
        pin(193, 52, 1'b0, "lz05_cell1_no_e");
        scan();
        fs(8'h00, 1'b1, 1'b0);
        pin(161, 33, 1'b0, "lz00_cell0");
        pin(193, 33, 1'b1, "lz00_cell1");
        scan();

        // Digits changing mid-frame are not displayed until the next frame_start
        fs(8'h11, 1'b0, 1'b0);
        pin(175, 40, 1'b1, "d11_b");
        @(negedge clk7_159);
        digits = 8'h22;
        scan();
        pin(162, 52, 1'b0, "latch_hold");
        fs(8'h22, 1'b0, 1'b0);
        pin(162, 52, 1'b1, "latch_new");

        // Invalid codes
        fs(8'hAF, 1'b0, 1'b0);
        pin(175, 40, 1'b0, "invalid_A");
        pin(193, 33, 1'b0, "invalid_F");
        scan();

        // Blink with BLINK_FRAMES=2, disabled at frame 7
        for (int i = 0; i < 9; i++) begin
            fs(8'h88, 1'b0, (i >= 7) ? 1'b0 : 1'b1);
            pin(175, 40, blink_exp[i], $sformatf("blink_f%0d", i));
        end

        // Reset mid-frame while a lit pixel is in the pipeline
        pin(166, 48, 1'b1, "pre_reset_lit");
        @(negedge clk7_159);
        reset = 1'b1;
        @(negedge clk7_159);
        check_lit("rst_c1", 1'b0);
        reset = 1'b0;
        @(negedge clk7_159);
        check_lit("rst_c2", 1'b0);
        @(negedge clk7_159);
        check_lit("rst_c3", 1'b0);
        pin(175, 40, 1'b1, "rst_shadow_00_d0");
        pin(207, 40, 1'b1, "rst_shadow_00_d1");
        scan();

        @(negedge clk7_159);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
